// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: scan FSM states and
// active-high gfedcba segment patterns for hex digits 0..F.
package seven_seg_scanner_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [7:0] CATHODES_OFF = 8'hFF;

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module hex_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        o_segments = SEG_8;
        case (i_nibble)
            4'h0: o_segments = SEG_0;
            4'h1: o_segments = SEG_1;
            4'h2: o_segments = SEG_2;
            4'h3: o_segments = SEG_3;
            4'h4: o_segments = SEG_4;
            4'h5: o_segments = SEG_5;
            4'h6: o_segments = SEG_6;
            4'h7: o_segments = SEG_7;
            4'h8: o_segments = SEG_8;
            4'h9: o_segments = SEG_9;
            4'hA: o_segments = SEG_A;
            4'hB: o_segments = SEG_B;
            4'hC: o_segments = SEG_C;
            4'hD: o_segments = SEG_D;
            4'hE: o_segments = SEG_E;
            4'hF: o_segments = SEG_F;
            default: o_segments = SEG_8;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit seven-segment driver with per-slot dark gap
// and once-per-frame input shadowing; all pins are driven from registers.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    i_clk100,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_digitEnable,
    input  logic [NUM_DIGITS-1:0]   i_dots,
    input  logic                    i_blank,
    output logic [7:0]              o_cathodes,
    output logic [NUM_DIGITS-1:0]   o_anodes,
    output logic                    o_frameStart
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
    logic [NUM_DIGITS-1:0]   shadow_dots_q, shadow_dots_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic [7:0]              cathodes_q, cathodes_d;
    logic                    frame_start_q, frame_start_d;
    logic [3:0]              nibble;
    logic [6:0]              segments;
    logic                    lit;

    // Shadow next-state lives in its own block so the decoder input does not
    // loop back into the block that consumes the decoder output.
    always_comb begin
        shadow_value_d = shadow_value_q;
        shadow_en_d    = shadow_en_q;
        shadow_dots_d  = shadow_dots_q;
        frame_start_d  = 1'b0;
        if (state_q == ST_BLANK && idx_q == '0 && cnt_q == '0) begin
            shadow_value_d = i_value;
            shadow_en_d    = i_digitEnable;
            shadow_dots_d  = i_dots;
            frame_start_d  = 1'b1;
        end
    end

    assign nibble = shadow_value_d[idx_q*4 +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nibble   (nibble),
        .o_segments (segments)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        lit        = 1'b0;
        anodes_d   = '1;
        cathodes_d = CATHODES_OFF;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    lit     = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_q == DIGIT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    lit = 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
        // i_blank only gates the pins; the slot timing keeps running underneath.
        if (lit && shadow_en_d[idx_q] && !i_blank) begin
            anodes_d   = ~(NUM_DIGITS'(1) << idx_q);
            cathodes_d = ~{shadow_dots_d[idx_q], segments};
        end
    end

    always_ff @(posedge i_clk100) begin
        if (i_reset) begin
            // NOTE: the shadow is reset along with the FSM so the pins never show undefined data.
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_value_q <= '0;
            shadow_en_q    <= '0;
            shadow_dots_q  <= '0;
            anodes_q       <= '1;
            cathodes_q     <= CATHODES_OFF;
            frame_start_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_value_q <= shadow_value_d;
            shadow_en_q    <= shadow_en_d;
            shadow_dots_q  <= shadow_dots_d;
            anodes_q       <= anodes_d;
            cathodes_q     <= cathodes_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign o_anodes     = anodes_q;
    assign o_cathodes   = cathodes_q;
    assign o_frameStart = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: vector table, hand-written
// corner sequences, and a randomized run against a cycle-position model.
module tb_seven_seg_scanner;

    localparam int N     = 8;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * DC;

    logic          i_clk100 = 1'b0;
    logic          i_reset  = 1'b1;
    logic [31:0]   i_value  = '0;
    logic [7:0]    i_digitEnable = '0;
    logic [7:0]    i_dots   = '0;
    logic          i_blank  = 1'b0;
    logic [7:0]    o_cathodes;
    logic [7:0]    o_anodes;
    logic          o_frameStart;

    seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .i_clk100      (i_clk100),
        .i_reset       (i_reset),
        .i_value       (i_value),
        .i_digitEnable (i_digitEnable),
        .i_dots        (i_dots),
        .i_blank       (i_blank),
        .o_cathodes    (o_cathodes),
        .o_anodes      (o_anodes),
        .o_frameStart  (o_frameStart)
    );

    always #5 i_clk100 = ~i_clk100;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16];

    // Reference model state: edges since reset release plus the frame shadow.
    int          mt;
    logic [31:0] m_value;
    logic [7:0]  m_en;
    logic [7:0]  m_dots;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  enable;
        logic [7:0]  dots;
        int          digit;
        logic [7:0]  exp_anodes;
        logic [7:0]  exp_cathodes;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk100);
        #1;
    endtask

    // Startup sequence after reset release: frame pulse, digit 0 lit 6, dark 2, digit 1.
    task automatic startup_seq(input string tag);
        logic [7:0] exp_an [10];
        exp_an = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("%s anodes edge %0d", tag, k), {24'h0, o_anodes}, {24'h0, exp_an[k]});
            check($sformatf("%s frameStart edge %0d", tag, k), {31'h0, o_frameStart}, {31'h0, (k == 0)});
        end
    endtask

    task automatic hold_reset(input int n, input string tag);
        i_reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            check($sformatf("%s reset anodes", tag), {24'h0, o_anodes}, 32'hFF);
            check($sformatf("%s reset cathodes", tag), {24'h0, o_cathodes}, 32'hFF);
            check($sformatf("%s reset frameStart", tag), {31'h0, o_frameStart}, 32'h0);
        end
        i_reset = 1'b0;
    endtask

    task automatic rand_step();
        logic [7:0] ea, ec;
        logic       ef;
        int         pos, d;
        ea = 8'hFF;
        ec = 8'hFF;
        ef = 1'b0;
        if (i_reset) begin
            mt = 0;
        end else begin
            if (mt % FRAME == 0) begin
                m_value = i_value;
                m_en    = i_digitEnable;
                m_dots  = i_dots;
                ef      = 1'b1;
            end
            pos = mt % DC;
            d   = (mt / DC) % N;
            if (pos >= BC - 1 && pos <= DC - 2 && m_en[d] && !i_blank) begin
                ea = ~(8'h01 << d);
                ec = ~{m_dots[d], seg_tab[m_value[4*d +: 4]]};
            end
            mt++;
        end
        tick();
        check("rand anodes", {24'h0, o_anodes}, {24'h0, ea});
        check("rand cathodes", {24'h0, o_cathodes}, {24'h0, ec});
        check("rand frameStart", {31'h0, o_frameStart}, {31'h0, ef});
        if ($urandom_range(0, 99) == 0) i_value = $urandom;
        if ($urandom_range(0, 149) == 0) i_digitEnable = 8'($urandom);
        if ($urandom_range(0, 149) == 0) i_dots = 8'($urandom);
        if ($urandom_range(0, 24) == 0) i_blank = ~i_blank;
        i_reset = ($urandom_range(0, 599) == 0);
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        vecs[0] = '{32'h01234567, 8'hFF, 8'h00, 0, 8'hFE, 8'hF8};
        vecs[1] = '{32'h01234567, 8'hFF, 8'h00, 1, 8'hFD, 8'h82};
        vecs[2] = '{32'h01234567, 8'hFF, 8'h00, 7, 8'h7F, 8'hC0};
        vecs[3] = '{32'h01234567, 8'hFF, 8'h01, 0, 8'hFE, 8'h78};
        vecs[4] = '{32'hFFFFFFFF, 8'hFF, 8'h00, 3, 8'hF7, 8'h8E};
        vecs[5] = '{32'h89ABCDEF, 8'h00, 8'hFF, 2, 8'hFF, 8'hFF};
        vecs[6] = '{32'h89ABCDEF, 8'hFF, 8'h80, 7, 8'h7F, 8'h00};
        vecs[7] = '{32'h89ABCDEF, 8'hFF, 8'h80, 4, 8'hEF, 8'h83};
        vecs[8] = '{32'h89ABCDEF, 8'hFF, 8'h04, 2, 8'hFB, 8'h21};
        vecs[9] = '{32'h01234567, 8'hF7, 8'h00, 3, 8'hFF, 8'hFF};

        // Scenario 1: reset and startup timing.
        i_value = 32'h01234567;
        i_digitEnable = 8'hFF;
        hold_reset(3, "s1");
        startup_seq("s1");

        // Table: mid-ON sample of the chosen digit in the first frame.
        foreach (vecs[i]) begin
            i_value       = vecs[i].value;
            i_digitEnable = vecs[i].enable;
            i_dots        = vecs[i].dots;
            i_reset = 1'b1;
            tick();
            i_reset = 1'b0;
            repeat (DC * vecs[i].digit + 4) tick();
            check($sformatf("vec%0d anodes", i), {24'h0, o_anodes}, {24'h0, vecs[i].exp_anodes});
            check($sformatf("vec%0d cathodes", i), {24'h0, o_cathodes}, {24'h0, vecs[i].exp_cathodes});
        end

        // Scenario 3: mid-frame value change does not tear.
        i_value = 32'h01234567;
        i_digitEnable = 8'hFF;
        i_dots = 8'h00;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        repeat (28) tick();
        i_value = 32'hFFFFFFFF;
        repeat (8) tick();
        check("s3 old digit4 anodes", {24'h0, o_anodes}, 32'hEF);
        check("s3 old digit4 cathodes", {24'h0, o_cathodes}, 32'hB0);
        repeat (32) tick();
        check("s3 new digit0 anodes", {24'h0, o_anodes}, 32'hFE);
        check("s3 new digit0 cathodes", {24'h0, o_cathodes}, 32'h8E);

        // Scenario 6: reset during digit-5 ON window restarts cleanly.
        i_value = 32'h01234567;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        repeat (DC * 5 + 4) tick();
        check("s6 digit5 anodes", {24'h0, o_anodes}, 32'hDF);
        check("s6 digit5 cathodes", {24'h0, o_cathodes}, 32'hA4);
        hold_reset(1, "s6");
        startup_seq("s6");

        // Randomized run against the position model (covers blanking, enables, frame period).
        i_reset = 1'b1;
        mt = 0;
        m_value = '0;
        m_en = '0;
        m_dots = '0;
        for (int k = 0; k < 4000; k++) rand_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
